// File: rtl/gcd_pkg.sv
// Shared types and constants for the gcd scheduler and its round-robin picker.
package gcd_pkg;

    localparam int GCD_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        WAIT,
        RESP
    } state_e;

    // The timeout counter must be able to hold the value TIMEOUT itself.
    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/gcd_rr_pick.sv
// Combinational round-robin picker: returns the first set request strictly
// after the pointer, wrapping modulo N.
module gcd_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin : pick
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                idx_o    = IW'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one gcd unit between N requesters: round-robin grant, load/result
// sequencing, local zero-operand bypass and a WAIT timeout.
//   state  | meaning
//   IDLE   | arbitrate, grant one requester and capture its operands
//   LOAD   | one-cycle load pulse to the gcd
//   SETTLE | resultReady may be stale here and is ignored; timer cleared
//   WAIT   | wait for resultReady or timeout
//   RESP   | hold response until the owner accepts it
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = GCD_W,
    parameter int TIMEOUT = 1023
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   resp_valid,
    input  logic [N-1:0]   resp_ready,
    output logic [W-1:0]   resp_data,
    output logic           resp_error,
    output logic           load,
    output logic [W-1:0]   dataA,
    output logic [W-1:0]   dataB,
    input  logic           resultReady,
    input  logic [W-1:0]   resultData,
    output logic           busy
);

    localparam int            IW       = $clog2(N);
    localparam int            CW       = tmo_width(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT);

    state_e        state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] owner_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  data_q;
    logic          err_q;
    logic          load_q;
    logic [N-1:0]  resp_valid_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [W-1:0]  pick_a;
    logic [W-1:0]  pick_b;
    logic [N-1:0]  owner_oh;

    gcd_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign pick_a   = req_a[int'(pick_idx) * W +: W];
    assign pick_b   = req_b[int'(pick_idx) * W +: W];
    assign owner_oh = {{(N-1){1'b0}}, 1'b1} << owner_q;
    assign cnt_d    = cnt_q + 1'b1;

    // Grant is combinational, so it is also gated by reset to keep every output low in reset.
    assign req_ready  = (state_q == IDLE && reset) ? pick_gnt : '0;
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = data_q;
    assign resp_error = err_q;
    assign load       = load_q;
    assign dataA      = a_q;
    assign dataB      = b_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= IW'(N - 1);
            owner_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            load_q       <= 1'b0;
            resp_valid_q <= '0;
            cnt_q        <= '0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        ptr_q   <= pick_idx;
                        owner_q <= pick_idx;
                        a_q     <= pick_a;
                        b_q     <= pick_b;
                        // gcd(0,x)=x and gcd(0,0)=0, answered without the gcd unit.
                        if (pick_a == '0 || pick_b == '0) begin
                            data_q       <= pick_a | pick_b;
                            err_q        <= 1'b0;
                            resp_valid_q <= pick_gnt;
                            state_q      <= RESP;
                        end else begin
                            load_q  <= 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: state_q <= SETTLE;
                SETTLE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (resultReady) begin
                        data_q       <= resultData;
                        err_q        <= 1'b0;
                        resp_valid_q <= owner_oh;
                        state_q      <= RESP;
                    end else if (cnt_d == TMO_LAST) begin
                        data_q       <= '0;
                        err_q        <= 1'b1;
                        resp_valid_q <= owner_oh;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
